nco_derotator: RTL and testbench

NCO_DEROTATOR -- requirements
Module: nco_derotator

---
 rtl/nco_derotator.sv | 286 ++++++++++++++++++++++++++++
 tb/tb_nco_derotator.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_derotator.sv
`default_nettype none
// ============================================================================
//  Module      : nco_derotator
//  Description : Carrier derotator. A phase accumulator driven by the
//                per-sample phase correction addresses a quarter-wave sine
//                table, and each I/Q sample is rotated by -phi through a
//                4-stage pipeline (address, table read, products,
//                sum + saturate).
//                Optional carrier lock detector enabled by defining
//                NCO_DEROTATOR_LOCK_DETECT_EN; without it o_lock is tied 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module nco_derotator #(
  parameter int                  NB_DATA     = 16,
  parameter int                  NB_PHASE    = 16,
  parameter int                  NB_LUT_ADDR = 10,
  parameter logic [NB_PHASE-1:0] LOCK_THR    = NB_PHASE'(16'h0080),
  parameter int                  LOCK_CNT    = 64
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_valid,
  input  logic signed [NB_DATA-1:0]  i_real,
  input  logic signed [NB_DATA-1:0]  i_imag,
  input  logic signed [NB_PHASE-1:0] i_phase_inc,
  output logic                       o_valid,
  output logic signed [NB_DATA-1:0]  o_real,
  output logic signed [NB_DATA-1:0]  o_imag,
  output logic                       o_lock
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  // Number of quarter-wave steps; the table stores entries 0..c_q inclusive so
  // that the quadrant fold never needs an address outside the table.
  localparam int c_q  = 2 ** (NB_LUT_ADDR - 2);
  localparam int c_pw = 2 * NB_DATA;      // product width
  localparam int c_sw = 2 * NB_DATA + 1;  // sum width

  localparam logic [NB_LUT_ADDR-2:0]  c_q_idx        = (NB_LUT_ADDR-1)'(c_q);
  localparam logic [NB_LUT_ADDR-1:0]  c_quarter_addr = NB_LUT_ADDR'(c_q);
  localparam logic signed [c_sw-1:0]  c_sat_max      = c_sw'((2 ** (NB_DATA - 1)) - 1);
  localparam logic signed [c_sw-1:0]  c_sat_min      = -c_sat_max - c_sw'(1);

  // --------------------------------------------------------------------------
  // Elaboration-time parameter sanity checks
  // --------------------------------------------------------------------------
  if (NB_LUT_ADDR < 3 || NB_LUT_ADDR > NB_PHASE) begin : g_bad_lut_addr
    $error("nco_derotator: NB_LUT_ADDR must be in [3, NB_PHASE]");
  end
  if (LOCK_CNT < 1) begin : g_bad_lock_cnt
    $error("nco_derotator: LOCK_CNT must be at least 1");
  end
  if (LOCK_THR[NB_PHASE-1]) begin : g_bad_lock_thr
    $error("nco_derotator: LOCK_THR must be below half a turn");
  end

  // --------------------------------------------------------------------------
  // Quarter-wave sine table
  // --------------------------------------------------------------------------
  // round(32767 * sin((pi/2) * k / c_q)) evaluated with wide fixed-point
  // integer arithmetic (scale 2^60) via a Taylor series, so the table is
  // exact to the rounding of the ideal value without relying on real math.
  function automatic int quarter_sine(input int k);
    logic [127:0] pi_fx;
    logic [127:0] x;
    logic [127:0] x2;
    logic [127:0] term;
    logic [127:0] acc_pos;
    logic [127:0] acc_neg;
    logic [127:0] val;
    pi_fx   = 128'h3243F6A8885A308D;  // pi * 2^60
    x       = (pi_fx * 128'(k)) >> (NB_LUT_ADDR - 1);
    x2      = (x * x) >> 60;
    term    = x;
    acc_pos = x;
    acc_neg = '0;
    for (int n = 1; n <= 12; n++) begin
      term = ((term * x2) >> 60) / 128'((2 * n) * (2 * n + 1));
      if ((n % 2) == 1) acc_neg = acc_neg + term;
      else              acc_pos = acc_pos + term;
    end
    val = (acc_pos - acc_neg) * 128'd32767 + (128'd1 << 59);
    return int'(val >> 60);
  endfunction

  logic signed [NB_DATA-1:0] w_qrom [0:c_q];

  for (genvar g = 0; g <= c_q; g++) begin : g_qrom
    localparam int c_val = quarter_sine(g);
    assign w_qrom[g] = NB_DATA'(c_val);
  end

  // Folds a full-turn address onto the quarter table: returns
  // {negate, table_index}. Quadrants 1 and 3 mirror the index; 2 and 3 negate.
  function automatic logic [NB_LUT_ADDR-1:0] fold_addr(input logic [NB_LUT_ADDR-1:0] a);
    logic [NB_LUT_ADDR-2:0] off;
    off = {1'b0, a[NB_LUT_ADDR-3:0]};
    if (a[NB_LUT_ADDR-2]) off = c_q_idx - off;
    return {a[NB_LUT_ADDR-1], off};
  endfunction

  // Floor-quantised sum to output range with saturation.
  function automatic logic signed [NB_DATA-1:0] saturate(input logic signed [c_sw-1:0] v);
    if (v > c_sat_max)      return c_sat_max[NB_DATA-1:0];
    else if (v < c_sat_min) return c_sat_min[NB_DATA-1:0];
    else                    return v[NB_DATA-1:0];
  endfunction

  // --------------------------------------------------------------------------
  // Pipeline registers
  // --------------------------------------------------------------------------
  logic [NB_PHASE-1:0]       r_phi;
  logic                      r1_valid;
  logic [NB_LUT_ADDR-1:0]    r1_addr;
  logic signed [NB_DATA-1:0] r1_re;
  logic signed [NB_DATA-1:0] r1_im;

  logic                      r2_valid;
  logic signed [NB_DATA-1:0] r2_sin;
  logic signed [NB_DATA-1:0] r2_cos;
  logic signed [NB_DATA-1:0] r2_re;
  logic signed [NB_DATA-1:0] r2_im;

  logic                      r3_valid;
  logic signed [c_pw-1:0]    r3_re_cos;
  logic signed [c_pw-1:0]    r3_im_sin;
  logic signed [c_pw-1:0]    r3_im_cos;
  logic signed [c_pw-1:0]    r3_re_sin;

  logic                      r_out_valid;
  logic signed [NB_DATA-1:0] r_out_re;
  logic signed [NB_DATA-1:0] r_out_im;

  // Stage 1: latch the table address from phi before this sample's update.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_phi    <= '0;
      r1_valid <= 1'b0;
      r1_addr  <= '0;
      r1_re    <= '0;
      r1_im    <= '0;
    end else begin
      r1_valid <= i_valid;
      if (i_valid) begin
        r_phi   <= r_phi + $unsigned(i_phase_inc);
        r1_addr <= r_phi[NB_PHASE-1 -: NB_LUT_ADDR];
        r1_re   <= i_real;
        r1_im   <= i_imag;
      end
    end
  end

  // Table lookup: cos(a) is sin(a + quarter turn), both read from the fold.
  logic [NB_LUT_ADDR-1:0]    w_cos_addr;
  logic [NB_LUT_ADDR-1:0]    w_sin_fold;
  logic [NB_LUT_ADDR-1:0]    w_cos_fold;
  logic signed [NB_DATA-1:0] w_sin_mag;
  logic signed [NB_DATA-1:0] w_cos_mag;

  assign w_cos_addr = r1_addr + c_quarter_addr;
  assign w_sin_fold = fold_addr(r1_addr);
  assign w_cos_fold = fold_addr(w_cos_addr);
  assign w_sin_mag  = w_qrom[w_sin_fold[NB_LUT_ADDR-2:0]];
  assign w_cos_mag  = w_qrom[w_cos_fold[NB_LUT_ADDR-2:0]];

  // Stage 2: register signed sine/cosine alongside the sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r2_valid <= 1'b0;
      r2_sin   <= '0;
      r2_cos   <= '0;
      r2_re    <= '0;
      r2_im    <= '0;
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_sin <= w_sin_fold[NB_LUT_ADDR-1] ? -w_sin_mag : w_sin_mag;
        r2_cos <= w_cos_fold[NB_LUT_ADDR-1] ? -w_cos_mag : w_cos_mag;
        r2_re  <= r1_re;
        r2_im  <= r1_im;
      end
    end
  end

  // Stage 3: four full-precision products.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r3_valid  <= 1'b0;
      r3_re_cos <= '0;
      r3_im_sin <= '0;
      r3_im_cos <= '0;
      r3_re_sin <= '0;
    end else begin
      r3_valid <= r2_valid;
      if (r2_valid) begin
        r3_re_cos <= c_pw'(r2_re) * c_pw'(r2_cos);
        r3_im_sin <= c_pw'(r2_im) * c_pw'(r2_sin);
        r3_im_cos <= c_pw'(r2_im) * c_pw'(r2_cos);
        r3_re_sin <= c_pw'(r2_re) * c_pw'(r2_sin);
      end
    end
  end

  // Rotation sums, then floor by arithmetic shift of the fractional bits.
  logic signed [c_sw-1:0] w_sum_re;
  logic signed [c_sw-1:0] w_sum_im;
  logic signed [c_sw-1:0] w_sh_re;
  logic signed [c_sw-1:0] w_sh_im;

  assign w_sum_re = c_sw'(r3_re_cos) + c_sw'(r3_im_sin);
  assign w_sum_im = c_sw'(r3_im_cos) - c_sw'(r3_re_sin);
  assign w_sh_re  = w_sum_re >>> (NB_DATA - 1);
  assign w_sh_im  = w_sum_im >>> (NB_DATA - 1);

  // Stage 4: saturated output; data holds while no valid sample arrives.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
    end else begin
      r_out_valid <= r3_valid;
      if (r3_valid) begin
        r_out_re <= saturate(w_sh_re);
        r_out_im <= saturate(w_sh_im);
      end
    end
  end

  assign o_valid = r_out_valid;
  assign o_real  = r_out_re;
  assign o_imag  = r_out_im;

  // --------------------------------------------------------------------------
  // Carrier lock detector
  // --------------------------------------------------------------------------
`ifdef NCO_DEROTATOR_LOCK_DETECT_EN
  localparam int                 c_cnt_w   = $clog2(LOCK_CNT + 1);
  localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(LOCK_CNT);

  logic [NB_PHASE-1:0] w_abs_inc;
  logic                w_in_thr;
  logic [c_cnt_w-1:0]  w_lock_cnt_nxt;
  logic [c_cnt_w-1:0]  r_lock_cnt;
  logic                r_lock;

  // Magnitude of the correction (most negative value clamps to the maximum)
  // and the saturating run-length of in-threshold samples.
  always_comb begin
    w_abs_inc      = i_phase_inc;
    w_lock_cnt_nxt = r_lock_cnt;
    if (i_phase_inc[NB_PHASE-1]) begin
      if (i_phase_inc == {1'b1, {(NB_PHASE-1){1'b0}}})
        w_abs_inc = {1'b0, {(NB_PHASE-1){1'b1}}};
      else
        w_abs_inc = -i_phase_inc;
    end
    w_in_thr = (w_abs_inc <= LOCK_THR);
    if (i_valid) begin
      if (!w_in_thr)
        w_lock_cnt_nxt = '0;
      else if (r_lock_cnt != c_cnt_max)
        w_lock_cnt_nxt = r_lock_cnt + c_cnt_w'(1);
    end
  end

  // Count and lock flag update together so lock drops right after a bad sample.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_lock_cnt <= '0;
      r_lock     <= 1'b0;
    end else begin
      r_lock_cnt <= w_lock_cnt_nxt;
      r_lock     <= (w_lock_cnt_nxt == c_cnt_max);
    end
  end

  assign o_lock = r_lock;
`else
  assign o_lock = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nco_derotator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nco_derotator
//  Description : Self-checking bench for nco_derotator. A driver issues
//                directed and random samples and pushes the reference
//                result (computed from trigonometry) into a scoreboard; a
//                monitor pops and compares on every o_valid and checks data
//                hold, latency and the lock flag every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nco_derotator;

  localparam real PI = 3.14159265358979323846;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic               in_valid = 1'b0;
  logic signed [15:0] in_real = '0;
  logic signed [15:0] in_imag = '0;
  logic signed [15:0] in_inc = '0;
  logic               out_valid;
  logic signed [15:0] out_real;
  logic signed [15:0] out_imag;
  logic               out_lock;

  nco_derotator dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (in_valid),
    .i_real      (in_real),
    .i_imag      (in_imag),
    .i_phase_inc (in_inc),
    .o_valid     (out_valid),
    .o_real      (out_real),
    .o_imag      (out_imag),
    .o_lock      (out_lock)
  );

  always #5 clk = ~clk;

  typedef struct {
    int re;
    int im;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   phi_m = 0;     // reference phase accumulator, 0..65535
  int   run_m = 0;     // consecutive in-threshold samples (capped)
  bit   exp_lock = 1'b0;
  int   last_re = 0;
  int   last_im = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  function automatic int rnd(input real x);
    if (x >= 0.0) return $rtoi(x + 0.5);
    else          return -$rtoi(-x + 0.5);
  endfunction

  function automatic int sat16(input longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  // Reference: table angle from the top 10 phase bits, ideal rounded sine,
  // cosine as sine a quarter turn ahead, floor and saturate.
  function automatic void predict(input int phi, input int re, input int im,
                                  output int ore, output int oim);
    int a;
    int s;
    int c;
    longint pr;
    longint pq;
    a  = phi >> 6;
    s  = rnd(32767.0 * $sin(2.0 * PI * a / 1024.0));
    c  = rnd(32767.0 * $sin(2.0 * PI * ((a + 256) % 1024) / 1024.0));
    pr = longint'(re) * c + longint'(im) * s;
    pq = longint'(im) * c - longint'(re) * s;
    ore = sat16(pr >>> 15);
    oim = sat16(pq >>> 15);
  endfunction

  // Drive one cycle (valid or idle); entered and left just after a negedge.
  task automatic send(input bit v, input logic signed [15:0] re,
                      input logic signed [15:0] im, input logic signed [15:0] inc);
    int ore;
    int oim;
    int mag;
    in_valid = v;
    in_real  = re;
    in_imag  = im;
    in_inc   = inc;
    @(posedge clk);
    if (v) begin
      predict(phi_m, int'(re), int'(im), ore, oim);
      sb.push_back('{ore, oim, cyc});
      phi_m = (phi_m + int'(inc)) & 32'h0000_FFFF;
      mag = (int'(inc) < 0) ? ((int'(inc) == -32768) ? 32767 : -int'(inc)) : int'(inc);
      if (mag <= 128) run_m = (run_m < 64) ? run_m + 1 : 64;
      else            run_m = 0;
`ifdef NCO_DEROTATOR_LOCK_DETECT_EN
      exp_lock = (run_m == 64);
`else
      exp_lock = 1'b0;
`endif
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Asynchronous reset asserted between clock edges while data is in flight.
  task automatic async_reset();
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_real", int'(out_real), 0);
    chk("rst_imag", int'(out_imag), 0);
    chk("rst_lock", int'(out_lock), 0);
    sb.delete();
    phi_m    = 0;
    run_m    = 0;
    exp_lock = 1'b0;
    last_re  = 0;
    last_im  = 0;
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: every cycle check lock and data hold; on o_valid pop and compare.
  always @(negedge clk) begin
    exp_t e;
    chk("lock", int'(out_lock), int'(exp_lock));
    if (out_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got (%0d,%0d) expected no output (t=%0t)",
                 out_real, out_imag, $time);
      end else begin
        e = sb.pop_front();
        chk("out_real", int'(out_real), e.re);
        chk("out_imag", int'(out_imag), e.im);
        chk("latency", cyc - e.cyc, 4);
      end
      last_re = int'(out_real);
      last_im = int'(out_imag);
    end else begin
      chk("hold_real", int'(out_real), last_re);
      chk("hold_imag", int'(out_imag), last_im);
    end
  end

  // Watchdog: the stimulus is bounded, this only guards against a stall.
  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic signed [15:0] re;
    logic signed [15:0] im;
    logic signed [15:0] inc;
    bit                 v;
    int                 sel;

    // Power-on reset
    #1;
    rst = 1'b1;
    #2;
    chk("por_valid", int'(out_valid), 0);
    chk("por_real", int'(out_real), 0);
    chk("por_imag", int'(out_imag), 0);
    chk("por_lock", int'(out_lock), 0);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);

    // Zero rotation: (0x4000,0) -> (0x3FFF,0)
    send(1'b1, 16'sh4000, 16'sh0000, 16'sh0000);
    repeat (5) send(1'b0, '0, '0, '0);

    // Quarter-turn steps: (0x3FFF,0) then (0,0xC000)
    send(1'b1, 16'sh4000, 16'sh0000, 16'sh4000);
    send(1'b1, 16'sh4000, 16'sh0000, 16'sh4000);
    repeat (5) send(1'b0, '0, '0, '0);

    // Move phi from 0x8000 to 0x2000, then saturating 45-degree rotation
    send(1'b1, 16'sh0000, 16'sh0000, 16'shA000);
    send(1'b1, 16'sh7FFF, 16'sh7FFF, 16'sh0000);
    repeat (5) send(1'b0, '0, '0, '0);

    // Reset with three samples in flight; next samples restart from phi=0
    send(1'b1, 16'sh1234, 16'sh5678, 16'sh1111);
    send(1'b1, 16'sh2345, -16'sh1000, 16'sh2222);
    send(1'b1, -16'sh3000, 16'sh0F00, 16'sh3333);
    async_reset();

    // Wrap: three samples at +0x7FFF, the third uses phi=0xFFFE
    for (int n = 0; n < 3; n++) begin
      re = 16'($urandom);
      im = 16'($urandom);
      send(1'b1, re, im, 16'sh7FFF);
    end
    repeat (5) send(1'b0, '0, '0, '0);

    // Random stream with gaps, extreme data and phase corrections
    for (int n = 0; n < 400; n++) begin
      v   = ($urandom_range(0, 9) < 7);
      re  = 16'($urandom);
      im  = 16'($urandom);
      sel = int'($urandom_range(0, 5));
      if ($urandom_range(0, 7) == 0) re = 16'sh8000;
      if ($urandom_range(0, 7) == 0) im = 16'sh7FFF;
      case (sel)
        0:       inc = 16'($urandom);
        1:       inc = 16'(int'($urandom_range(0, 400)) - 200);
        2:       inc = 16'sh8000;
        3:       inc = 16'sh7FFF;
        4:       inc = ($urandom_range(0, 1) == 0) ? 16'sh0080 : -16'sh0080;
        default: inc = 16'sh0081;
      endcase
      send(v, re, im, inc);
    end
    repeat (5) send(1'b0, '0, '0, '0);

    // Lock acquisition: clear run, then 64 small corrections
    send(1'b1, 16'sh0100, 16'sh0000, 16'sh0100);
    for (int n = 0; n < 64; n++) begin
      re = 16'($urandom);
      im = 16'($urandom);
      send(1'b1, re, im, 16'sh0010);
`ifdef NCO_DEROTATOR_LOCK_DETECT_EN
      if (n == 62) chk("lock_at_63", int'(out_lock), 0);
      if (n == 63) chk("lock_at_64", int'(out_lock), 1);
`else
      if (n == 63) chk("lock_at_64", int'(out_lock), 0);
`endif
    end
    repeat (3) send(1'b0, '0, '0, '0);
`ifdef NCO_DEROTATOR_LOCK_DETECT_EN
    chk("lock_over_gap", int'(out_lock), 1);
`else
    chk("lock_over_gap", int'(out_lock), 0);
`endif
    send(1'b1, 16'sh0200, 16'sh0300, 16'sh0100);
    chk("lock_drop", int'(out_lock), 0);

    // Threshold boundary: +/-0x0080 count as in-threshold, 0x8000 does not
    for (int n = 0; n < 64; n++) begin
      send(1'b1, 16'($urandom), 16'($urandom), (n % 2 == 0) ? 16'sh0080 : -16'sh0080);
    end
`ifdef NCO_DEROTATOR_LOCK_DETECT_EN
    chk("lock_at_thr", int'(out_lock), 1);
`else
    chk("lock_at_thr", int'(out_lock), 0);
`endif
    send(1'b1, 16'sh0000, 16'sh0400, 16'sh8000);
    chk("lock_drop_min", int'(out_lock), 0);

    // Drain and confirm every issued sample came out
    repeat (8) send(1'b0, '0, '0, '0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
